// File: rtl/abcde_dot_seq_ctrl.sv
// ============================================================================
//  Module      : abcde_dot_seq_ctrl
//  Description : Sequences one abcde_dot_nxn checksum pass, then captures the
//                dot products and checks de == ae + be + ce (mod 2^Z_BITS).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module abcde_dot_seq_ctrl #(
    parameter int ARRAY_SIZE    = 4,
    parameter int ADDRESS_WIDTH = 2,
    parameter int Z_BITS        = 28,
    parameter int PIPE_LAT      = 3,
    parameter int ERR_CNT_BITS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] selector,
    output logic                     clear,
    input  logic [Z_BITS-1:0]        ae_dot,
    input  logic [Z_BITS-1:0]        be_dot,
    input  logic [Z_BITS-1:0]        ce_dot,
    input  logic [Z_BITS-1:0]        de_dot,
    output logic [Z_BITS-1:0]        ae_res,
    output logic [Z_BITS-1:0]        be_res,
    output logic [Z_BITS-1:0]        ce_res,
    output logic [Z_BITS-1:0]        de_res,
    output logic                     chk_err,
    output logic [ERR_CNT_BITS-1:0]  err_count
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] c_last_beat  = ADDRESS_WIDTH'(ARRAY_SIZE - 1);
    localparam logic [DRAIN_W-1:0]       c_last_drain = DRAIN_W'(PIPE_LAT - 1);
    localparam logic [ERR_CNT_BITS-1:0]  c_err_max    = {ERR_CNT_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACC     = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDRESS_WIDTH-1:0] r_beat;
    logic [DRAIN_W-1:0]       r_drain;
    logic [Z_BITS-1:0]        w_sum;
    logic                     w_capture;

    assign w_sum     = ae_dot + be_dot + ce_dot;
    assign w_capture = (r_state == S_CAPTURE) && !abort;

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        selector = '0;
        clear    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done   = (r_state == S_DONE);
                w_next = (start && !abort) ? S_ACC : S_IDLE;
            end
            S_ACC: begin
                busy     = 1'b1;
                selector = r_beat;
                clear    = (r_beat == '0);
                if (abort)                     w_next = S_IDLE;
                else if (r_beat == c_last_beat) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                // Selector parks on the final beat while the datapath drains.
                busy     = 1'b1;
                selector = c_last_beat;
                if (abort)                       w_next = S_IDLE;
                else if (r_drain == c_last_drain) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                busy   = 1'b1;
                w_next = abort ? S_IDLE : S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            r_beat  <= (r_state == S_ACC && w_next == S_ACC)
                       ? r_beat + ADDRESS_WIDTH'(1) : '0;
            r_drain <= (r_state == S_DRAIN && w_next == S_DRAIN)
                       ? r_drain + DRAIN_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ae_res    <= '0;
            be_res    <= '0;
            ce_res    <= '0;
            de_res    <= '0;
            chk_err   <= 1'b0;
            err_count <= '0;
        end else if (w_capture) begin
            ae_res  <= ae_dot;
            be_res  <= be_dot;
            ce_res  <= ce_dot;
            de_res  <= de_dot;
            chk_err <= (w_sum != de_dot);
            if ((w_sum != de_dot) && (err_count != c_err_max))
                err_count <= err_count + ERR_CNT_BITS'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_abcde_dot_seq_ctrl.sv
// ============================================================================
//  Module      : tb_abcde_dot_seq_ctrl
//  Description : Directed bench with a pass-phase reference model for
//                abcde_dot_seq_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_abcde_dot_seq_ctrl;

    localparam int N  = 4;
    localparam int L  = 3;
    localparam int ZB = 28;
    localparam int P  = N + L + 2;   // cycle index of done within a pass

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic          busy, done, clear, chk_err;
    logic [1:0]    selector;
    logic [ZB-1:0] ae_dot, be_dot, ce_dot, de_dot;
    logic [ZB-1:0] ae_res, be_res, ce_res, de_res;
    logic [7:0]    err_count;

    always #5 clk = ~clk;

    abcde_dot_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .selector(selector), .clear(clear),
        .ae_dot(ae_dot), .be_dot(be_dot), .ce_dot(ce_dot), .de_dot(de_dot),
        .ae_res(ae_res), .be_res(be_res), .ce_res(ce_res), .de_res(de_res),
        .chk_err(chk_err), .err_count(err_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pass is tracked as its cycle index 1..P (0 = idle).
    int            m_phase = 0;
    bit            m_valid = 0;
    logic [ZB-1:0] m_ae = '0, m_be = '0, m_ce = '0, m_de = '0;
    bit            m_chk = 0;
    int            m_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_valid = 1;
            m_ae = '0; m_be = '0; m_ce = '0; m_de = '0;
            m_chk = 0; m_cnt = 0;
        end else if (m_phase == 0 || m_phase == P) begin
            m_phase = (start && !abort) ? 1 : 0;
        end else if (abort) begin
            m_phase = 0;
        end else begin
            if (m_phase == P - 1) begin
                longint s;
                s = (longint'(ae_dot) + longint'(be_dot) + longint'(ce_dot)) % (64'd1 << ZB);
                m_ae = ae_dot; m_be = be_dot; m_ce = ce_dot; m_de = de_dot;
                m_chk = (s != longint'(de_dot));
                if (m_chk && m_cnt < 255) m_cnt++;
            end
            m_phase++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int exp_sel;
            exp_sel = (m_phase >= 1 && m_phase <= N) ? m_phase - 1 :
                      (m_phase > N && m_phase <= N + L) ? N - 1 : 0;
            check("m_busy",     busy,     (m_phase >= 1 && m_phase <= P - 1));
            check("m_done",     done,     (m_phase == P));
            check("m_selector", selector, exp_sel);
            check("m_clear",    clear,    (m_phase == 1));
            check("m_ae_res",   ae_res,   m_ae);
            check("m_be_res",   be_res,   m_be);
            check("m_ce_res",   ce_res,   m_ce);
            check("m_de_res",   de_res,   m_de);
            check("m_chk_err",  chk_err,  m_chk);
            check("m_err_count", err_count, m_cnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one pass and returns in the cycle where done is high.
    task automatic run_pass();
        bit got;
        got = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            tick();
        end
        if (!got) check("pass_timeout", 0, 1);
    endtask

    initial begin
        int dones;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ae_dot = '0; be_dot = '0; ce_dot = '0; de_dot = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt",  err_count, 0);
        rst = 1'b0;
        tick();

        // Pass timing from a start at cycle 0
        ae_dot = 28'd10; be_dot = 28'd20; ce_dot = 28'd30; de_dot = 28'd60;
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            check("t1_clear", clear,    (c == 1));
            check("t1_sel",   selector, (c <= 4) ? c - 1 : (c <= 7) ? 3 : 0);
            check("t1_busy",  busy,     (c <= 8));
            check("t1_done",  done,     (c == 9));
        end
        check("t1_ae_res", ae_res, 10);
        check("t1_de_res", de_res, 60);
        check("t1_chk",    chk_err, 0);
        check("t1_cnt",    err_count, 0);

        // Checksum mismatch
        de_dot = 28'd61;
        run_pass();
        check("t2_chk", chk_err, 1);
        check("t2_cnt", err_count, 1);
        tick();

        // Wrapping sum
        ae_dot = 28'hFFF_FFFF; be_dot = 28'd1; ce_dot = 28'd0; de_dot = 28'd0;
        run_pass();
        check("t3_chk", chk_err, 0);
        check("t3_cnt", err_count, 1);
        tick();

        // Abort in the third cycle of a pass
        de_dot = 28'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_sel",  selector, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("t4_no_done", dones, 0);
        check("t4_ae_res",  ae_res, 28'hFFF_FFFF);
        check("t4_de_res",  de_res, 0);
        check("t4_cnt",     err_count, 1);

        // Abort beats start in the same idle cycle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("t4b_busy", busy, 0);
        tick();
        check("t4b_busy2", busy, 0);

        // Start held high: passes chain through the done cycle
        ae_dot = 28'd1; be_dot = 28'd2; ce_dot = 28'd3; de_dot = 28'd6;
        start = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("t5_dones", dones, 3);
        check("t5_cnt",   err_count, 1);

        // Saturation of the mismatch counter
        ae_dot = '0; be_dot = '0; ce_dot = '0; de_dot = 28'd1;
        for (int k = 0; k < 300; k++) run_pass();
        check("t6_cnt", err_count, 255);
        check("t6_chk", chk_err, 1);
        tick();

        // Reset in the middle of a pass
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_busy",   busy, 0);
        check("t7_sel",    selector, 0);
        check("t7_clear",  clear, 0);
        check("t7_ae_res", ae_res, 0);
        check("t7_de_res", de_res, 0);
        check("t7_chk",    chk_err, 0);
        check("t7_cnt",    err_count, 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        check("t7_no_done", dones, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
